// File: rtl/quadrature_encoder.sv
// quadrature_encoder: emits N full A/B quadrature cycles per command, each phase held D+1 clocks,
// and mirrors the count a downstream quadrature decoder is expected to hold.
module quadrature_encoder #(
    parameter int STEP_WIDTH = 8,
    parameter int DIV_WIDTH  = 8,
    parameter int POS_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [STEP_WIDTH-1:0] cmd_steps,
    input  logic [DIV_WIDTH-1:0]  phase_div,
    input  logic                  abort,
    output logic                  A,
    output logic                  B,
    output logic                  busy,
    output logic                  done,
    output logic [POS_WIDTH-1:0]  position
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                state;
    logic                  dir;
    logic                  abort_seen;
    logic [STEP_WIDTH-1:0] steps;
    logic [DIV_WIDTH-1:0]  div;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [1:0]            phase;
    logic                  hold_end;
    logic                  stop;

    // Phase 0 is the leading-channel phase; phase 3 is the 00 rest that closes a step.
    function automatic logic [1:0] phase_ab(input logic [1:0] p, input logic d);
        return p == 2'd3 ? 2'b00 : p == 2'd1 ? 2'b11 : (p == 2'd0) == d ? 2'b01 : 2'b10;
    endfunction

    assign cmd_ready = state == IDLE && !reset;

    always_comb begin
        hold_end = div_cnt == div;
        stop     = steps == STEP_WIDTH'(1) || abort_seen || abort;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            {A, B}     <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            position   <= '0;
            dir        <= 1'b0;
            abort_seen <= 1'b0;
            steps      <= '0;
            div        <= '0;
            div_cnt    <= '0;
            phase      <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    dir        <= cmd_dir;
                    steps      <= cmd_steps;
                    div        <= phase_div;
                    div_cnt    <= '0;
                    phase      <= '0;
                    abort_seen <= 1'b0;
                    if (cmd_steps == '0) begin
                        done <= 1'b1;
                    end else begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        {A, B}   <= phase_ab(2'd0, cmd_dir);
                        position <= cmd_dir ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
                    end
                end
            end else begin
                abort_seen <= abort_seen | abort;
                if (!hold_end) begin
                    div_cnt <= div_cnt + DIV_WIDTH'(1);
                end else begin
                    div_cnt <= '0;
                    if (phase != 2'd3) begin
                        phase  <= phase + 2'd1;
                        {A, B} <= phase_ab(phase + 2'd1, dir);
                    end else if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        steps    <= steps - STEP_WIDTH'(1);
                        phase    <= '0;
                        {A, B}   <= phase_ab(2'd0, dir);
                        position <= dir ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_quadrature_encoder.sv
// tb_quadrature_encoder: table-driven and randomized checks of quadrature_encoder against a
// cycle-trace model, with a behavioural x4 decoder in loopback.
module tb_quadrature_encoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_steps = '0;
    logic [7:0] phase_div = '0;
    logic       abort = 1'b0;
    logic       A, B, busy, done;
    logic [7:0] position;

    int checks = 0;
    int failures = 0;
    int pos_model = 0;
    int dec_q = 0;
    logic [1:0] prev_ab = 2'b00;
    logic prev_reset = 1'b1;

    typedef struct {
        int dir;
        int n;
        int d;
        int abort_off;
        int exp_len;
        int exp_delta;
    } vec_t;
    vec_t tbl[6];

    quadrature_encoder dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .phase_div(phase_div), .abort(abort),
        .A(A), .B(B), .busy(busy), .done(done), .position(position)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_ab(input int dir, input int ph);
        int fwd[4] = '{1, 3, 2, 0};
        int rev[4] = '{2, 3, 1, 0};
        return dir != 0 ? fwd[ph] : rev[ph];
    endfunction

    function automatic int gray_idx(input logic [1:0] ab);
        int idx[4] = '{0, 1, 3, 2};
        return idx[ab];
    endfunction

    // Entered at the negedge of the accept cycle T; returns at the negedge of the done cycle.
    task automatic run_cmd(input int dir, input int n, input int d, input int abort_off,
                           output int obs_len, output int obs_delta);
        int per, done_steps, len, start, stp, ph, exp_pos;
        per = 4 * (d + 1);
        done_steps = n;
        if (abort_off > 0 && n > 0)
            done_steps = ((abort_off - 1) / per + 1) < n ? ((abort_off - 1) / per + 1) : n;
        len = per * done_steps;
        start = pos_model;
        chk("ready_at_accept", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_dir = dir[0];
        cmd_steps = n[7:0];
        phase_div = d[7:0];
        obs_len = -1;
        for (int i = 1; i <= len + 1; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cmd_valid = 1'b0;
                cmd_dir = 1'($urandom);
                cmd_steps = 8'($urandom);
                phase_div = 8'($urandom);
            end
            if (i == abort_off) abort = 1'b1;
            if (done && obs_len < 0) obs_len = i - 1;
            if (i <= len) begin
                stp = (i - 1) / per;
                ph = ((i - 1) / (d + 1)) % 4;
                exp_pos = (start + (dir != 0 ? stp + 1 : -(stp + 1))) & 255;
                chk("ab_phase", int'({A, B}), model_ab(dir, ph));
                chk("position_run", int'(position), exp_pos);
                chk("busy_run", int'(busy), 1);
                chk("done_run", int'(done), 0);
            end else begin
                chk("done_pulse", int'(done), 1);
                chk("busy_end", int'(busy), 0);
                chk("ab_idle", int'({A, B}), 0);
                chk("ready_end", int'(cmd_ready), 1);
            end
        end
        abort = 1'b0;
        pos_model = (start + (dir != 0 ? done_steps : -done_steps)) & 255;
        chk("position_final", int'(position), pos_model);
        obs_delta = ((int'(position) - start + 128) & 255) - 128;
    endtask

    // Behavioural x4 decoder plus the one-bit-per-edge rule, skipped across reset.
    always @(negedge clk) begin
        if (!reset && !prev_reset) begin
            if ({A, B} != prev_ab) begin
                checks++;
                if (A != prev_ab[1] && B != prev_ab[0]) begin
                    failures++;
                    $display("FAIL ab_single_edge: got %b after %b at %0t", {A, B}, prev_ab, $time);
                end
                case ((gray_idx({A, B}) - gray_idx(prev_ab)) & 3)
                    1: dec_q = dec_q + 1;
                    3: dec_q = dec_q - 1;
                    default: ;
                endcase
            end
        end else begin
            dec_q = 0;
        end
        prev_ab = {A, B};
        prev_reset = reset;
    end

    initial begin
        int obs_len, obs_delta, dir, n, d, ab_off;
        tbl[0] = '{1, 1, 0, 0, 4, 1};
        tbl[1] = '{0, 2, 2, 0, 24, -2};
        tbl[2] = '{1, 3, 0, 0, 12, 3};
        tbl[3] = '{1, 0, 3, 0, 0, 0};
        tbl[4] = '{1, 10, 1, 3, 8, 1};
        tbl[5] = '{0, 4, 1, 12, 16, -2};

        repeat (3) @(negedge clk);
        chk("rst_ab", int'({A, B}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_position", int'(position), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(cmd_ready), 1);

        for (int i = 0; i < 6; i++) begin
            run_cmd(tbl[i].dir, tbl[i].n, tbl[i].d, tbl[i].abort_off, obs_len, obs_delta);
            chk("tbl_len", obs_len, tbl[i].exp_len);
            chk("tbl_delta", obs_delta, tbl[i].exp_delta);
            if (i != 3) begin
                @(negedge clk);
                chk("done_once", int'(done), 0);
            end
        end

        // Reset in the middle of a run: outputs clear, no done, ready returns after reset.
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd5; phase_div = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrun_ab", int'({A, B}), 3);
        chk("midrun_pos", int'(position), (pos_model + 2) & 255);
        reset = 1'b1;
        @(negedge clk);
        chk("rstrun_ab", int'({A, B}), 0);
        chk("rstrun_pos", int'(position), 0);
        chk("rstrun_busy", int'(busy), 0);
        chk("rstrun_done", int'(done), 0);
        chk("rstrun_ready", int'(cmd_ready), 0);
        reset = 1'b0;
        pos_model = 0;
        @(negedge clk);
        chk("rstrun_ready_after", int'(cmd_ready), 1);
        chk("rstrun_no_done", int'(done), 0);

        for (int k = 0; k < 24; k++) begin
            dir = int'($urandom_range(0, 1));
            n = int'($urandom_range(0, 6));
            d = int'($urandom_range(0, 3));
            ab_off = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 * (d + 1) * n + 1)) : 0;
            run_cmd(dir, n, d, ab_off, obs_len, obs_delta);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("rand_done_once", int'(done), 0);
            end
        end

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pos_model = 0;
        @(negedge clk);
        run_cmd(1, 150, 0, 0, obs_len, obs_delta);
        run_cmd(1, 150, 0, 0, obs_len, obs_delta);
        chk("loop_position", int'(position), 44);
        chk("loop_decoder", (dec_q / 4) & 255, 44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
